// File: rtl/ps2_key_joy_if.sv
// Pin and key-vector bundle between the PS/2 front end and its consumer.
// The debug field exposes the receiver state for external checkers.
interface ps2_key_joy_if;
    logic       i_ps2_clk;
    logic       i_ps2_data;
    logic [9:0] o_key_joy1;
    logic [9:0] o_key_joy2;
    logic       o_four_players;
    logic       o_frame_err;
    logic [1:0] dbg_rx_state;

    modport master (
        output i_ps2_clk, i_ps2_data,
        input  o_key_joy1, o_key_joy2, o_four_players, o_frame_err, dbg_rx_state
    );

    modport slave (
        input  i_ps2_clk, i_ps2_data,
        output o_key_joy1, o_key_joy2, o_four_players, o_frame_err, dbg_rx_state
    );
endinterface

// File: rtl/ps2_key_joy.sv
// PS/2 keyboard receiver and scancode decoder producing held-key vectors for
// both paddles plus a 2/4 player toggle driven by F2.
module ps2_key_joy #(
    parameter logic [19:0] TIMEOUT = 20'd500000,
    parameter logic [3:0]  FILTER  = 4'd8
) (
    input  logic          clock,
    input  logic          reset_n,
    ps2_key_joy_if.slave  bus
);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Both pins idle high, so the synchronisers reset to 1 to avoid a false edge.
    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus.i_ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.i_ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    logic       flt_clk_q, flt_clk_d;
    logic [3:0] flt_cnt_q, flt_cnt_d;
    logic       fall_edge;

    always_comb begin
        flt_clk_d = flt_clk_q;
        flt_cnt_d = flt_cnt_q;
        if (clk_s2_q == flt_clk_q) begin
            flt_cnt_d = 4'd0;
        end else if (flt_cnt_q == FILTER - 4'd1) begin
            flt_clk_d = clk_s2_q;
            flt_cnt_d = 4'd0;
        end else begin
            flt_cnt_d = flt_cnt_q + 4'd1;
        end
        fall_edge = flt_clk_q & ~flt_clk_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flt_clk_q <= 1'b1;
            flt_cnt_q <= 4'd0;
        end else begin
            flt_clk_q <= flt_clk_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    rx_state_e  rx_state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [19:0] tmo_q;
    logic       byte_stb_q;
    logic [7:0] byte_q;
    logic       err_q;

    // par_q accumulates data+parity; it must end at 1 for odd parity.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tmo_q      <= 20'd0;
            byte_stb_q <= 1'b0;
            byte_q     <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            byte_stb_q <= 1'b0;
            err_q      <= 1'b0;
            if (fall_edge) begin
                tmo_q <= 20'd0;
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!dat_s2_q) begin
                            rx_state_q <= RX_DATA;
                            bit_cnt_q  <= 3'd0;
                            par_q      <= 1'b0;
                        end
                    end
                    RX_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        par_q     <= par_q ^ dat_s2_q;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q      <= par_q ^ dat_s2_q;
                        rx_state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        rx_state_q <= RX_IDLE;
                        if (dat_s2_q && par_q) begin
                            byte_stb_q <= 1'b1;
                            byte_q     <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end else if (rx_state_q != RX_IDLE) begin
                if (tmo_q == TIMEOUT - 20'd1) begin
                    rx_state_q <= RX_IDLE;
                    err_q      <= 1'b1;
                    tmo_q      <= 20'd0;
                end else begin
                    tmo_q <= tmo_q + 20'd1;
                end
            end
        end
    end

    logic       ext_q, ext_d, brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic [9:0] joy1_q, joy1_d, joy2_q, joy2_d;
    logic       four_q, four_d;
    logic       make;
    logic [8:0] key;

    // Pause (E1) emits 8 bytes; the E1 itself plus 7 skipped bytes are ignored.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        joy1_d = joy1_q;
        joy2_d = joy2_q;
        make   = ~brk_q;
        key    = {ext_q, byte_q};
        if (byte_stb_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == 8'hE1) begin
                skip_d = 3'd7;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                case (key)
                    9'h174: joy1_d[0] = make;
                    9'h16B: joy1_d[1] = make;
                    9'h172: joy1_d[2] = make;
                    9'h175: joy1_d[3] = make;
                    9'h114: joy1_d[4] = make;
                    9'h059: joy1_d[5] = make;
                    9'h05A: joy1_d[6] = make;
                    9'h076: joy1_d[7] = make;
                    9'h005: joy1_d[8] = make;
                    9'h006: joy1_d[9] = make;
                    9'h023: joy2_d[0] = make;
                    9'h01C: joy2_d[1] = make;
                    9'h01A: joy2_d[2] = make;
                    9'h015: joy2_d[3] = make;
                    9'h029: joy2_d[4] = make;
                    9'h012: joy2_d[5] = make;
                    9'h016: joy2_d[6] = make;
                    9'h01E: joy2_d[7] = make;
                    9'h026: joy2_d[8] = make;
                    9'h025: joy2_d[9] = make;
                    default: ;
                endcase
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        four_d = four_q ^ (joy1_d[9] & ~joy1_q[9]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
            joy1_q <= 10'd0;
            joy2_q <= 10'd0;
            four_q <= 1'b0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            joy1_q <= joy1_d;
            joy2_q <= joy2_d;
            four_q <= four_d;
        end
    end

    assign bus.o_key_joy1     = joy1_q;
    assign bus.o_key_joy2     = joy2_q;
    assign bus.o_four_players = four_q;
    assign bus.o_frame_err    = err_q;
    assign bus.dbg_rx_state   = rx_state_q;

endmodule

// File: tb/tb_ps2_key_joy.sv
// Bench for ps2_key_joy: PS/2 frame driver, table-driven key model, scenario tasks.
module tb_ps2_key_joy;

  localparam logic [19:0] TB_TIMEOUT = 20'd1000;
  localparam int HALF = 20;

  logic clock;
  logic reset_n;
  ps2_key_joy_if bus ();

  ps2_key_joy #(.TIMEOUT(TB_TIMEOUT), .FILTER(4'd8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  bit glitch_en = 0;

  always @(negedge clock) if (reset_n && bus.o_frame_err === 1'b1) err_seen++;

  // ---------------- reference model ----------------
  logic [8:0] map1 [10] = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h114,
                            9'h059, 9'h05A, 9'h076, 9'h005, 9'h006};
  logic [8:0] map2 [10] = '{9'h023, 9'h01C, 9'h01A, 9'h015, 9'h029,
                            9'h012, 9'h016, 9'h01E, 9'h026, 9'h025};
  logic [9:0] m_joy1, m_joy2;
  logic       m_four, m_ext, m_brk;
  int         m_skip;

  task automatic model_reset();
    m_joy1 = '0; m_joy2 = '0; m_four = 0; m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] k;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = {m_ext, b};
      for (int i = 0; i < 10; i++) begin
        if (map1[i] == k) begin
          if (i == 9 && !m_brk && !m_joy1[9]) m_four = ~m_four;
          m_joy1[i] = !m_brk;
        end
        if (map2[i] == k) m_joy2[i] = !m_brk;
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic ps2_bit(input logic b);
    bus.i_ps2_data = b;
    repeat (4) @(posedge clock);
    bus.i_ps2_clk = 1'b0;
    repeat (HALF) @(posedge clock);
    bus.i_ps2_clk = 1'b1;
    if (glitch_en) begin
      repeat (12) @(posedge clock);
      bus.i_ps2_clk = 1'b0;
      repeat (3) @(posedge clock);
      bus.i_ps2_clk = 1'b1;
      repeat (HALF - 19) @(posedge clock);
    end else begin
      repeat (HALF - 4) @(posedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    bus.i_ps2_data = 1'b1;
    repeat (HALF) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic send_key(input bit ext, input logic [7:0] code, input bit rel);
    if (ext) send_byte(8'hE0);
    if (rel) send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic do_reset();
    bus.i_ps2_clk = 1'b1;
    bus.i_ps2_data = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clock);
    reset_n = 1'b1;
    model_reset();
    repeat (5) @(posedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== 10'd0) begin errors++; $display("FAIL reset_joy1 got=%h exp=000", bus.o_key_joy1); end
    checks++; if (bus.o_key_joy2 !== 10'd0) begin errors++; $display("FAIL reset_joy2 got=%h exp=000", bus.o_key_joy2); end
    checks++; if (bus.o_four_players !== 1'b0) begin errors++; $display("FAIL reset_four got=%b exp=0", bus.o_four_players); end
    checks++; if (bus.o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.o_frame_err); end
  endtask

  task automatic test_make_break();
    int e0;
    e0 = err_seen;
    send_key(0, 8'h15, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy2 !== 10'h008 || m_joy2 !== 10'h008) begin errors++; $display("FAIL make_q got=%h exp=008", bus.o_key_joy2); end
    send_key(0, 8'h15, 1);
    @(negedge clock);
    checks++; if (bus.o_key_joy2 !== 10'h000) begin errors++; $display("FAIL break_q got=%h exp=000", bus.o_key_joy2); end
    checks++; if (err_seen !== e0) begin errors++; $display("FAIL make_break_err got=%0d exp=%0d", err_seen, e0); end
  endtask

  task automatic test_extended();
    logic [9:0] j2;
    j2 = bus.o_key_joy2;
    send_key(1, 8'h75, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== m_joy1 || bus.o_key_joy1[3] !== 1'b1) begin errors++; $display("FAIL ext_up got=%h exp=%h", bus.o_key_joy1, m_joy1); end
    checks++; if (bus.o_key_joy2 !== j2) begin errors++; $display("FAIL ext_joy2 got=%h exp=%h", bus.o_key_joy2, j2); end
    send_key(0, 8'h75, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== m_joy1 || bus.o_key_joy2 !== m_joy2) begin errors++; $display("FAIL kp8 got=%h/%h exp=%h/%h", bus.o_key_joy1, bus.o_key_joy2, m_joy1, m_joy2); end
    send_key(1, 8'h75, 1);
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_seen;
    send_frame(8'h1C, 1'b1);
    @(negedge clock);
    checks++; if (err_seen !== e0 + 1) begin errors++; $display("FAIL parity_err got=%0d exp=%0d", err_seen, e0 + 1); end
    checks++; if (bus.o_key_joy2[1] !== 1'b0) begin errors++; $display("FAIL parity_drop got=%b exp=0", bus.o_key_joy2[1]); end
    send_key(0, 8'h1C, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy2 !== m_joy2 || bus.o_key_joy2[1] !== 1'b1) begin errors++; $display("FAIL parity_next got=%h exp=%h", bus.o_key_joy2, m_joy2); end
    send_key(0, 8'h1C, 1);
  endtask

  task automatic test_f2_toggle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) send_key(0, 8'h06, 0);
      @(negedge clock);
      checks++; if (bus.o_key_joy1[9] !== 1'b1) begin errors++; $display("FAIL f2_held got=%b exp=1", bus.o_key_joy1[9]); end
      send_key(0, 8'h06, 1);
      @(negedge clock);
      checks++; if (bus.o_four_players !== m_four || m_four !== (r == 0)) begin errors++; $display("FAIL f2_toggle_%0d got=%b exp=%b", r, bus.o_four_players, m_four); end
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (int'(TB_TIMEOUT) + 200) @(posedge clock);
    @(negedge clock);
    checks++; if (err_seen !== e0 + 1) begin errors++; $display("FAIL timeout_err got=%0d exp=%0d", err_seen, e0 + 1); end
    send_key(0, 8'h1A, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy2 !== m_joy2 || bus.o_key_joy2[2] !== 1'b1) begin errors++; $display("FAIL timeout_next got=%h exp=%h", bus.o_key_joy2, m_joy2); end
    send_key(0, 8'h1A, 1);
  endtask

  task automatic test_reset_midframe();
    send_key(0, 8'h15, 0);
    send_key(1, 8'h75, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy1[3] !== 1'b1 || bus.o_key_joy2[3] !== 1'b1) begin errors++; $display("FAIL held_pre got=%h/%h exp bits set", bus.o_key_joy1, bus.o_key_joy2); end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.o_key_joy1, bus.o_key_joy2, bus.o_four_players} !== 21'd0) begin errors++; $display("FAIL midreset got=%h/%h/%b exp=0", bus.o_key_joy1, bus.o_key_joy2, bus.o_four_players); end
    do_reset();
    send_key(1, 8'h6B, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== m_joy1 || bus.o_key_joy1 !== 10'h002) begin errors++; $display("FAIL after_reset got=%h exp=002", bus.o_key_joy1); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_seen;
    glitch_en = 1;
    send_key(0, 8'h23, 0);
    send_key(1, 8'h72, 0);
    send_key(1, 8'h6B, 1);
    glitch_en = 0;
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== m_joy1 || bus.o_key_joy2 !== m_joy2) begin errors++; $display("FAIL glitch got=%h/%h exp=%h/%h", bus.o_key_joy1, bus.o_key_joy2, m_joy1, m_joy2); end
    checks++; if (err_seen !== e0) begin errors++; $display("FAIL glitch_err got=%0d exp=%0d", err_seen, e0); end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    send_key(0, 8'h29, 0);
    @(negedge clock);
    checks++; if (bus.o_key_joy1 !== m_joy1 || bus.o_key_joy2 !== m_joy2 || bus.o_key_joy2[4] !== 1'b1) begin errors++; $display("FAIL pause got=%h/%h exp=%h/%h", bus.o_key_joy1, bus.o_key_joy2, m_joy1, m_joy2); end
  endtask

  task automatic test_random();
    logic [7:0] pool [22] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h59, 8'h5A, 8'h76,
                              8'h05, 8'h06, 8'h23, 8'h1C, 8'h1A, 8'h15, 8'h29, 8'h12,
                              8'h16, 8'h1E, 8'h26, 8'h25, 8'h1B, 8'h2B};
    for (int n = 0; n < 24; n++) begin
      send_key(1'($urandom_range(0, 1)), pool[$urandom_range(0, 21)], 1'($urandom_range(0, 1)));
      @(negedge clock);
      checks++; if (bus.o_key_joy1 !== m_joy1) begin errors++; $display("FAIL rand_joy1_%0d got=%h exp=%h", n, bus.o_key_joy1, m_joy1); end
      checks++; if (bus.o_key_joy2 !== m_joy2) begin errors++; $display("FAIL rand_joy2_%0d got=%h exp=%h", n, bus.o_key_joy2, m_joy2); end
      checks++; if (bus.o_four_players !== m_four) begin errors++; $display("FAIL rand_four_%0d got=%b exp=%b", n, bus.o_four_players, m_four); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.i_ps2_clk = 1'b1;
    bus.i_ps2_data = 1'b1;
    model_reset();
    test_reset();
    test_make_break();
    test_extended();
    test_parity();
    test_f2_toggle();
    test_timeout();
    test_reset_midframe();
    test_glitch();
    test_pause();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
